// File: rtl/cordic_atan2_unfold.sv
// cordic_atan2_unfold: iterative CORDIC vectoring atan2 with quadrant unfold.
// Ports: clk, rst (sync, high); x_in/y_in Q8.24 with in_valid/in_ready;
// theta_out Q8.24 in [0, 2pi), quadrant_out, out_valid/out_ready.
module cordic_atan2_unfold #(
  parameter int ITERATIONS = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] theta_out,
  output logic [1:0]  quadrant_out,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int W = 35;
  localparam logic [31:0] PI2    = 32'h01921FB5;
  localparam logic [31:0] PI     = 32'h03243F6B;
  localparam logic [31:0] PI3H   = 32'h04B65F20;
  localparam logic [31:0] TWO_PI = 32'h06487ED5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    UNFOLD,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic signed [W-1:0] x_q, x_d;
  logic signed [W-1:0] y_q, y_d;
  logic signed [31:0]  z_q, z_d;
  logic [4:0]  it_q, it_d;
  logic [1:0]  fq_q, fq_d;
  logic        flat_q, flat_d;
  logic [31:0] theta_q, theta_d;
  logic [1:0]  quad_q, quad_d;

  logic signed [W-1:0] xe, ye;
  logic signed [W-1:0] xs, ys;
  logic signed [31:0]  atan_i;
  logic [31:0] phi;
  logic [31:0] th;
  logic [1:0]  th_quad;
  logic        xn, yn, yz;

  // round(atan(2^-i) * 2^24); beyond i=7 the cubic term
  // is below half an LSB so the entry is just 2^(24-i).
  function automatic logic signed [31:0] atan_rom(
    input logic [4:0] i
  );
    case (i)
      5'd0:    atan_rom = 32'sh00C90FDB;
      5'd1:    atan_rom = 32'sh0076B19C;
      5'd2:    atan_rom = 32'sh003EB6EC;
      5'd3:    atan_rom = 32'sh001FD5BB;
      5'd4:    atan_rom = 32'sh000FFAAE;
      5'd5:    atan_rom = 32'sh0007FF55;
      5'd6:    atan_rom = 32'sh0003FFEB;
      5'd7:    atan_rom = 32'sh0001FFFD;
      default: atan_rom = (i <= 5'd24) ?
                 (32'sd1 <<< (5'd24 - i)) : 32'sd0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    it_d    = it_q;
    fq_d    = fq_q;
    flat_d  = flat_q;
    theta_d = theta_q;
    quad_d  = quad_q;

    xn = x_in[31];
    yn = y_in[31];
    yz = (y_in == 32'd0);
    xe = {{(W-32){x_in[31]}}, x_in};
    ye = {{(W-32){y_in[31]}}, y_in};
    xs = x_q >>> it_q;
    ys = y_q >>> it_q;
    atan_i = atan_rom(it_q);

    // A pair on the x axis has phi of exactly zero;
    // this also pins the origin to theta 0.
    if (flat_q || z_q < 0)
      phi = 32'd0;
    else if (z_q > $signed(PI2))
      phi = PI2;
    else
      phi = z_q;

    unique case (fq_q)
      2'd0: th = phi;
      2'd1: th = PI - phi;
      2'd2: th = PI + phi;
      2'd3: th = TWO_PI - phi;
    endcase
    if (th == TWO_PI)
      th = 32'd0;

    th_quad = 2'd0;
    unique case (1'b1)
      th <= PI2:                th_quad = 2'd0;
      th > PI2  && th < PI:     th_quad = 2'd1;
      th >= PI  && th < PI3H:   th_quad = 2'd2;
      th >= PI3H:               th_quad = 2'd3;
    endcase

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d    = xn ? -xe : xe;
          y_d    = yn ? -ye : ye;
          z_d    = 32'sd0;
          it_d   = 5'd0;
          flat_d = yz;
          unique case (1'b1)
            !xn && !yn:        fq_d = 2'd0;
            xn && !yn && !yz:  fq_d = 2'd1;
            xn && (yn || yz):  fq_d = 2'd2;
            !xn && yn:         fq_d = 2'd3;
          endcase
          state_d = RUN;
        end
      end
      RUN: begin
        if (y_q >= 0) begin
          x_d = x_q + ys;
          y_d = y_q - xs;
          z_d = z_q + atan_i;
        end else begin
          x_d = x_q - ys;
          y_d = y_q + xs;
          z_d = z_q - atan_i;
        end
        it_d = it_q + 5'd1;
        if (it_q == 5'(ITERATIONS - 1))
          state_d = UNFOLD;
      end
      UNFOLD: begin
        theta_d = th;
        quad_d  = th_quad;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      it_q    <= '0;
      fq_q    <= '0;
      flat_q  <= 1'b0;
      theta_q <= '0;
      quad_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      it_q    <= it_d;
      fq_q    <= fq_d;
      flat_q  <= flat_d;
      theta_q <= theta_d;
      quad_q  <= quad_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign theta_out    = theta_q;
  assign quadrant_out = quad_q;

endmodule

// File: tb/tb_cordic_atan2_unfold.sv
// tb_cordic_atan2_unfold: directed and random checks of cordic_atan2_unfold
// against a real-valued atan2 reference.
module tb_cordic_atan2_unfold;

  localparam real PI_R  = 3.141592653589793;
  localparam real SC    = 16777216.0;
  localparam real TP_R  = 2.0 * PI_R * SC;
  localparam real H_R   = PI_R / 2.0 * SC;
  localparam int  LAT   = 26;
  localparam int  THRU  = 27;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x_in, y_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] theta_out;
  logic [1:0]  quadrant_out;
  logic        out_valid;
  logic        out_ready;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
  } req_t;

  req_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rnd_ready = 0;
  longint acc_t;

  cordic_atan2_unfold dut (
    .clk          (clk),
    .rst          (rst),
    .x_in         (x_in),
    .y_in         (y_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .theta_out    (theta_out),
    .quadrant_out (quadrant_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string nm, input bit ok,
                       input longint act, input longint req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic bit near(input logic [31:0] a,
                              input logic [31:0] b,
                              input int tol);
    longint d;
    d = longint'(a) - longint'(b);
    if (d > 64'sd52707178)  d -= 64'sd105414357;
    if (d < -64'sd52707178) d += 64'sd105414357;
    return (d <= tol) && (d >= -tol);
  endfunction

  function automatic real ideal_theta(input logic [31:0] x,
                                      input logic [31:0] y);
    real a;
    a = $atan2(real'($signed(y)), real'($signed(x)));
    if (a < 0.0) a += 2.0 * PI_R;
    return a * SC;
  endfunction

  // reference compare on every output handshake, plus hold stability
  initial begin
    bit pv, pr;
    logic [31:0] pt;
    logic [1:0] pq;
    req_t r;
    real id, d, md, b;
    int eq;
    pv = 0; pr = 0; pt = 0; pq = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0;
      end else begin
        if (out_valid && pv && !pr) begin
          check("hold_theta", theta_out == pt, theta_out, pt);
          check("hold_quad", quadrant_out == pq, quadrant_out, pq);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", 1'b0, theta_out, 0);
          end else begin
            r = exp_q.pop_front();
            if (r.x == 0 && r.y == 0) begin
              check("model_origin", theta_out == 0, theta_out, 0);
              check("model_origin_q", quadrant_out == 0,
                    quadrant_out, 0);
            end else begin
              id = ideal_theta(r.x, r.y);
              d = real'(theta_out) - id;
              if (d > TP_R / 2.0)  d -= TP_R;
              if (d < -TP_R / 2.0) d += TP_R;
              check("model_theta", d <= 32.0 && d >= -32.0,
                    theta_out, longint'(id));
              md = 1.0e30;
              for (int k = 0; k <= 4; k++) begin
                b = id - real'(k) * H_R;
                if (b < 0.0) b = -b;
                if (b < md) md = b;
              end
              if (md > 48.0) begin
                eq = 0;
                if (id >= H_R)       eq = 1;
                if (id >= 2.0 * H_R) eq = 2;
                if (id >= 3.0 * H_R) eq = 3;
                check("model_quad", quadrant_out == eq,
                      quadrant_out, eq);
              end
            end
          end
        end
        pv = out_valid;
        pr = out_ready;
        pt = theta_out;
        pq = quadrant_out;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y);
    int n;
    req_t r;
    n = 0;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 1'b0, 0, 1);
    x_in = x;
    y_in = y;
    in_valid = 1'b1;
    @(posedge clk);
    acc_t = $time;
    r.x = x;
    r.y = y;
    exp_q.push_back(r);
    #1;
    in_valid = 1'b0;
    x_in = $urandom;
    y_in = $urandom;
  endtask

  task automatic wait_out(output logic [31:0] th,
                          output logic [1:0] q,
                          output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    if (!out_valid) check("out_timeout", 1'b0, 0, 1);
    th = theta_out;
    q = quadrant_out;
  endtask

  task automatic dir(input string nm,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] et, input int tol,
                     input logic [1:0] eqd);
    logic [31:0] th;
    logic [1:0] q;
    int lat;
    send(x, y);
    wait_out(th, q, lat);
    check({nm, "_lat"}, lat == LAT, lat, LAT);
    check({nm, "_theta"}, near(th, et, tol), th, et);
    check({nm, "_quad"}, q == eqd, q, eqd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] th, th0;
    logic [1:0] q, q0;
    int lat;
    longint a0, ax, ay;
    logic signed [31:0] sx, sy;
    bit saw;
    int n;

    rst = 1'b1;
    in_valid = 1'b0;
    x_in = '0;
    y_in = '0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready == 1'b1, in_ready, 1);
    check("rst_out_valid", out_valid == 1'b0, out_valid, 0);
    check("rst_theta", theta_out == 0, theta_out, 0);
    check("rst_quad", quadrant_out == 0, quadrant_out, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    dir("x_axis", 32'h01000000, 32'h00000000, 32'h0, 0, 2'd0);
    dir("y_axis", 32'h00000000, 32'h01000000, 32'h01921FB5, 32, 2'd0);
    dir("q1_diag", 32'hFF000000, 32'h01000000, 32'h025B2F90, 32, 2'd1);
    dir("neg_x", 32'hFF000000, 32'h00000000, 32'h03243F6B, 32, 2'd2);
    dir("q3_diag", 32'h01000000, 32'hFF000000, 32'h057F6EFA, 32, 2'd3);
    dir("min_min", 32'h80000000, 32'h80000000, 32'h03ED4F46, 32, 2'd2);

    // back-to-back throughput with out_ready held high
    send(32'h00400000, 32'h02000000);
    a0 = acc_t;
    wait_out(th, q, lat);
    send(32'hFE000000, 32'hFF400000);
    check("throughput", (acc_t - a0) / 10 == THRU, (acc_t - a0) / 10, THRU);
    wait_out(th, q, lat);
    @(posedge clk);
    #1;

    // backpressure: outputs hold while out_ready is low
    out_ready = 1'b0;
    send(32'h00C00000, 32'hFE800000);
    wait_out(th0, q0, lat);
    check("bp_lat", lat == LAT, lat, LAT);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_theta", theta_out == th0, theta_out, th0);
      check("bp_valid", out_valid == 1'b1, out_valid, 1);
      check("bp_in_ready", in_ready == 1'b0, in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("hs_in_ready", in_ready == 1'b1, in_ready, 1);
    check("hs_out_valid", out_valid == 1'b0, out_valid, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;

    // reset in the middle of the iterations
    send(32'h01000000, 32'h00800000);
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_valid", out_valid == 1'b0, out_valid, 0);
    check("abort_theta", theta_out == 0, theta_out, 0);
    check("abort_quad", quadrant_out == 0, quadrant_out, 0);
    check("abort_ready", in_ready == 1'b1, in_ready, 1);
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) saw = 1;
    end
    check("abort_no_out", saw == 0, saw, 0);
    @(posedge clk);
    #1;
    dir("origin", 32'h0, 32'h0, 32'h0, 0, 2'd0);

    // random pairs with random backpressure
    rnd_ready = 1;
    for (int k = 0; k < 1000; k++) begin
      do begin
        sx = $signed($urandom) >>> $urandom_range(0, 7);
        sy = $signed($urandom) >>> $urandom_range(0, 7);
        case ($urandom_range(0, 15))
          0: sy = 0;
          1: sx = 0;
          2: sy = -sx;
          default: ;
        endcase
        ax = (sx < 0) ? -longint'(sx) : longint'(sx);
        ay = (sy < 0) ? -longint'(sy) : longint'(sy);
      end while (ax < 64'sd16777216 && ay < 64'sd16777216);
      send(sx, sy);
    end
    rnd_ready = 0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain", exp_q.size() == 0, exp_q.size(), 0);
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
